rx_code_correlator: RTL and testbench

RX_CODE_CORRELATOR -- requirements
Module: rx_code_correlator

---
 rtl/rx_code_correlator.sv | 167 ++++++++++++++++
 tb/tb_rx_code_correlator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_code_correlator.sv
// Receive-side matched filter for a phase-coded pulse: integrates tb samples per
// chip, then correlates the last N chips against the code latched at the sync edge.
module rx_code_correlator #(
    parameter int NB_DATA = 16,
    parameter int NB_REG  = 32,
    parameter int NB_OUT  = 38
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_sinc,
    input  logic [NB_REG-1:0]         i_codigo,
    input  logic [NB_REG-1:0]         i_numdig,
    input  logic [NB_REG-1:0]         i_tb,
    input  logic signed [NB_DATA-1:0] i_data,
    input  logic                      i_valid,
    output logic signed [NB_OUT-1:0]  o_data,
    output logic                      o_valid,
    output logic [15:0]               o_bin,
    output logic                      o_busy,
    output logic                      o_err
);
    localparam int MAXN = 32;

    typedef enum logic {IDLE, ACQ} state_t;

    state_t                   state_q, state_d;
    logic                     sinc_q;
    logic [MAXN-1:0]          code_q, code_d;
    logic [5:0]               numdig_q, numdig_d;
    logic [15:0]              tb_q, tb_d;
    logic [15:0]              samp_q, samp_d;
    logic [15:0]              chipcnt_q, chipcnt_d;
    logic signed [31:0]       acc_q, acc_d;
    logic signed [31:0]       acc_sum, data_ext;
    logic signed [31:0]       chip_q [MAXN];
    logic signed [31:0]       chip_d [MAXN];
    logic                     dump_q, dump_d;
    logic signed [NB_OUT-1:0] corr, corr_q;
    logic                     corr_v_q, corr_v_d;
    logic [15:0]              bin_q, bin_d;
    logic signed [NB_OUT-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic [15:0]              obin_q, obin_d;
    logic                     err_q, err_d;
    logic                     sync_edge, cfg_ok, accept;
    logic                     unused_tb;

    assign sync_edge = i_sinc & ~sinc_q;
    assign cfg_ok    = (i_numdig != '0) && (i_numdig <= NB_REG'(MAXN)) && (i_tb[15:0] != '0);
    assign data_ext  = 32'(i_data);
    assign unused_tb = ^i_tb[NB_REG-1:16];

    always_comb begin
        state_d = state_q;
        if (sync_edge) begin
            state_d = cfg_ok ? ACQ : IDLE;
        end
    end

    // chip_q[0] is the newest chip, so chip_q[j] pairs with code bit j
    always_comb begin
        corr = '0;
        for (int unsigned j = 0; j < MAXN; j++) begin
            if (j < 32'(numdig_q)) begin
                if (code_q[j[4:0]]) corr = corr + NB_OUT'(chip_q[j[4:0]]);
                else                corr = corr - NB_OUT'(chip_q[j[4:0]]);
            end
        end
    end

    always_comb begin
        code_d    = code_q;
        numdig_d  = numdig_q;
        tb_d      = tb_q;
        samp_d    = samp_q;
        acc_d     = acc_q;
        chip_d    = chip_q;
        chipcnt_d = chipcnt_q;
        err_d     = err_q;
        dump_d    = 1'b0;
        acc_sum   = '0;
        corr_v_d  = dump_q && (chipcnt_q >= {10'd0, numdig_q}) && !sync_edge;
        bin_d     = chipcnt_q - {10'd0, numdig_q};
        valid_d   = corr_v_q && !sync_edge;
        data_d    = valid_d ? corr_q : data_q;
        obin_d    = valid_d ? bin_q : obin_q;
        accept    = (state_q == ACQ) && i_valid;

        if (sync_edge) begin
            accept = cfg_ok && i_valid;
            err_d  = !cfg_ok;
            if (cfg_ok) begin
                code_d    = i_codigo[MAXN-1:0];
                numdig_d  = i_numdig[5:0];
                tb_d      = i_tb[15:0];
                samp_d    = '0;
                acc_d     = '0;
                chipcnt_d = '0;
                chip_d    = '{default: '0};
            end
        end

        // a sample accepted on the sync edge lands in the freshly cleared window
        if (accept) begin
            acc_sum = acc_d + data_ext;
            if (samp_d == tb_d - 16'd1) begin
                for (int unsigned i = MAXN - 1; i > 0; i--) begin
                    chip_d[i[4:0]] = chip_d[i[4:0] - 5'd1];
                end
                chip_d[0] = acc_sum;
                acc_d     = '0;
                samp_d    = '0;
                dump_d    = 1'b1;
                if (chipcnt_d != '1) chipcnt_d = chipcnt_d + 16'd1;
            end else begin
                acc_d  = acc_sum;
                samp_d = samp_d + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            sinc_q    <= 1'b0;
            code_q    <= '0;
            numdig_q  <= '0;
            tb_q      <= '0;
            samp_q    <= '0;
            acc_q     <= '0;
            chip_q    <= '{default: '0};
            chipcnt_q <= '0;
            dump_q    <= 1'b0;
            corr_q    <= '0;
            corr_v_q  <= 1'b0;
            bin_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            obin_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sinc_q    <= i_sinc;
            code_q    <= code_d;
            numdig_q  <= numdig_d;
            tb_q      <= tb_d;
            samp_q    <= samp_d;
            acc_q     <= acc_d;
            chip_q    <= chip_d;
            chipcnt_q <= chipcnt_d;
            dump_q    <= dump_d;
            corr_q    <= corr;
            corr_v_q  <= corr_v_d;
            bin_q     <= bin_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            obin_q    <= obin_d;
            err_q     <= err_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_bin   = obin_q;
    assign o_busy  = (state_q == ACQ);
    assign o_err   = err_q;
endmodule

// File: tb/tb_rx_code_correlator.sv
// Directed bench for rx_code_correlator with a sample/chip-level reference model.
module tb_rx_code_correlator;
    logic               clk = 1'b0;
    logic               rst, sinc, valid;
    logic [31:0]        codigo, numdig, tbv;
    logic signed [15:0] data;
    logic signed [37:0] o_data;
    logic               o_valid, o_busy, o_err;
    logic [15:0]        o_bin;

    rx_code_correlator #(.NB_DATA(16), .NB_REG(32), .NB_OUT(38)) dut (
        .i_clk(clk), .i_rst(rst), .i_sinc(sinc), .i_codigo(codigo),
        .i_numdig(numdig), .i_tb(tbv), .i_data(data), .i_valid(valid),
        .o_data(o_data), .o_valid(o_valid), .o_bin(o_bin),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct { int due; longint d; int b; } exp_t;
    exp_t   expq[$];
    int     errors = 0, checks = 0, cyc = 0;
    bit     armed = 0;
    bit     m_active, m_err, m_prev;
    int     m_n, m_tb, m_cnt, m_nch;
    logic [31:0] m_code;
    longint m_acc;
    longint m_chips[$];
    longint last_d, first_d, lastv_d;
    int     last_b, first_b, lastv_b, nvalid;

    always @(posedge clk) cyc++;

    task automatic check_val(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic accept_sample(input int e);
        longint s;
        m_acc += data;
        m_cnt++;
        if (m_cnt == m_tb) begin
            m_chips.push_back(m_acc);
            if (m_chips.size() > 32) void'(m_chips.pop_front());
            m_acc = 0;
            m_cnt = 0;
            if (m_nch < 65535) m_nch++;
            if (m_nch >= m_n) begin
                s = 0;
                for (int k = 0; k < m_n; k++) begin
                    if (m_code[m_n-1-k]) s += m_chips[m_chips.size()-m_n+k];
                    else                 s -= m_chips[m_chips.size()-m_n+k];
                end
                expq.push_back('{due: e + 2, d: s, b: m_nch - m_n});
            end
        end
    endtask

    task automatic model_edge(input int e);
        if (rst) begin
            m_active = 0; m_err = 0; m_prev = 0;
            m_acc = 0; m_cnt = 0; m_nch = 0;
            m_chips.delete();
            expq.delete();
            last_d = 0; last_b = 0;
        end else begin
            if (sinc && !m_prev) begin
                expq.delete();
                if (numdig >= 1 && numdig <= 32 && tbv[15:0] != 16'd0) begin
                    m_active = 1; m_err = 0;
                    m_n = int'(numdig); m_tb = int'(tbv[15:0]); m_code = codigo;
                    m_cnt = 0; m_acc = 0; m_nch = 0;
                    m_chips.delete();
                end else begin
                    m_active = 0; m_err = 1;
                end
            end
            m_prev = sinc;
            if (m_active && valid) accept_sample(e);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic signed [15:0] d);
        sinc = s; valid = v; data = d;
        @(posedge clk);
        #1;
        model_edge(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'sd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                e = expq.pop_front();
                check_val("o_valid", o_valid, 1);
                check_val("o_data", o_data, e.d);
                check_val("o_bin", o_bin, e.b);
                last_d = e.d; last_b = e.b;
                nvalid++;
                if (nvalid == 1) begin first_d = e.d; first_b = e.b; end
                lastv_d = e.d; lastv_b = e.b;
            end else begin
                check_val("o_valid_idle", o_valid, 0);
                check_val("o_data_hold", o_data, last_d);
                check_val("o_bin_hold", o_bin, last_b);
            end
            check_val("o_busy", o_busy, m_active);
            check_val("o_err", o_err, m_err);
        end
    end

    initial begin
        logic [31:0] bcode;
        rst = 1'b1; sinc = 1'b1; valid = 1'b1; data = 16'sd77;
        codigo = 32'h1; numdig = 32'd1; tbv = 32'd1;
        nvalid = 0; first_d = 0; first_b = 0; lastv_d = 0; lastv_b = 0;
        last_d = 0; last_b = 0;

        // reset wins over a simultaneous sync edge
        step(1'b1, 1'b1, 16'sd77);
        armed = 1;
        check_val("reset_busy", o_busy, 0);
        check_val("reset_data", o_data, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 16'sd0);

        // Barker-13
        bcode = 32'h1F35; codigo = bcode; numdig = 32'd13; tbv = 32'd4;
        nvalid = 0;
        for (int k = 0; k < 13; k++)
            for (int s = 0; s < 4; s++)
                step((k == 0 && s == 0), 1'b1, bcode[12-k] ? 16'sd1000 : -16'sd1000);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'sd0);
        check_val("barker_busy", o_busy, 1);
        idle(4);
        check_val("barker_first_data", first_d, 52000);
        check_val("barker_first_bin", first_b, 0);
        check_val("barker_count", nvalid, 6);

        // invalid configurations
        nvalid = 0;
        numdig = 32'd0;  step(1'b1, 1'b1, 16'sd5);
        check_val("numdig0_err", o_err, 1);
        check_val("numdig0_busy", o_busy, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'sd5);
        numdig = 32'd33; step(1'b1, 1'b1, 16'sd5);
        check_val("numdig33_err", o_err, 1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'sd5);
        numdig = 32'd4; tbv = 32'd0; step(1'b1, 1'b1, 16'sd5);
        check_val("tb0_err", o_err, 1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'sd5);
        check_val("invalid_no_valid", nvalid, 0);

        // N=1, tb=3, gapped valid
        codigo = 32'h1; numdig = 32'd1; tbv = 32'd3;
        step(1'b1, 1'b1, 16'sd5);
        check_val("valid_sync_clears_err", o_err, 0);
        for (int i = 1; i < 24; i++) step(1'b0, (i % 2 == 0), 16'sd5);
        idle(4);
        check_val("n1_count", nvalid, 4);
        check_val("n1_data", lastv_d, 15);
        check_val("n1_first_bin", first_b, 0);
        check_val("n1_last_bin", lastv_b, 3);

        // resync mid-chip discards partial chip
        codigo = 32'h3; numdig = 32'd2; tbv = 32'd8;
        step(1'b1, 1'b1, 16'sd100);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'sd100);
        nvalid = 0;
        step(1'b1, 1'b1, 16'sd7);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 16'sd7);
        idle(4);
        check_val("resync_count", nvalid, 1);
        check_val("resync_data", first_d, 112);
        check_val("resync_bin", first_b, 0);

        // full-scale negative samples across 32 chips
        codigo = 32'hFFFF_FFFF; numdig = 32'd32; tbv = 32'd64;
        nvalid = 0;
        step(1'b1, 1'b1, -16'sd32768);
        for (int i = 1; i < 32 * 64; i++) step(1'b0, 1'b1, -16'sd32768);
        idle(4);
        check_val("fullscale_count", nvalid, 1);
        check_val("fullscale_data", first_d, -64'sd67108864);

        // reset one cycle before an expected output
        codigo = 32'h1; numdig = 32'd1; tbv = 32'd1;
        nvalid = 0;
        step(1'b1, 1'b1, 16'sd9);
        rst = 1'b1;
        step(1'b0, 1'b0, 16'sd0);
        rst = 1'b0;
        check_val("rst_mid_valid", o_valid, 0);
        check_val("rst_mid_data", o_data, 0);
        check_val("rst_mid_bin", o_bin, 0);
        check_val("rst_mid_busy", o_busy, 0);
        idle(4);
        check_val("rst_mid_count", nvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
